// File: rtl/mdu.sv
// Iterative multiply/divide execution unit on the conveyor dispatch bus.
// Claims one ready MUL/MULHU/DIVU/REMU slot, iterates 32 cycles, writes back if the slot is unchanged.
module mdu (
  input  logic         clk,
  input  logic         reset,
  input  logic [23:0]  reg_start_flat,
  input  logic [703:0] reg_out_flat,
  output logic [23:0]  stamp_flat,
  output logic [7:0]   stamp_in,
  output logic [39:0]  take_flat,
  output logic [7:0]   take_in,
  output logic [4:0]   reg_search_out12,
  input  logic [31:0]  reg_out12,
  output logic [4:0]   reg_search_out13,
  input  logic [31:0]  reg_out13,
  output logic [4:0]   reg_search_in12,
  output logic [31:0]  reg_in12,
  output logic         reg_in12_start
);

  localparam logic [5:0] OP_MUL    = 6'h20;
  localparam logic [5:0] OP_MULHU  = 6'h21;
  localparam logic [5:0] OP_DIVU   = 6'h22;
  localparam logic [5:0] OP_REMU   = 6'h23;
  localparam logic [2:0] ST_READY  = 3'd1;
  localparam logic [2:0] ST_ISSUED = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] addr;
    logic [2:0]  tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

  cmd_t [7:0]       slots;
  logic [7:0][2:0]  slot_state;
  logic [7:0][2:0]  stamp_arr;
  logic [7:0][4:0]  take_arr;

  assign slots      = reg_out_flat;
  assign slot_state = reg_start_flat;
  assign stamp_flat = stamp_arr;
  assign take_flat  = take_arr;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_next;
  logic [31:0] opnd;
  logic [5:0]  op_q;
  logic [4:0]  rd_q;
  logic [2:0]  tag_q;
  logic [2:0]  idx_q;

  logic        cand_valid;
  logic [2:0]  cand_idx;
  logic        is_div;
  logic        wb_match;
  logic [32:0] add_sum;
  logic [33:0] diff;
  logic        unused_bits;

  // Lowest-numbered ready slot whose op is one of the four MDU opcodes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cand_valid = 1'b0;
    cand_idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (slot_state[k] == ST_READY && slots[k].op >= OP_MUL && slots[k].op <= OP_REMU) begin
        cand_valid = 1'b1;
        cand_idx   = 3'(k);
      end
    end
  end

  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < 8; k++) unused_bits = unused_bits ^ (^{slots[k].imm, slots[k].addr});
  end

  // DIVU/REMU have op bit 1 set; MULHU/REMU (bit 0) take the upper accumulator half.
  assign is_div   = op_q[1];
  assign wb_match = (slots[idx_q].op == op_q) && (slots[idx_q].tag == tag_q);

  // One iteration. Multiply: acc = {hi, multiplier}, add multiplicand into hi, shift right.
  // Divide: acc = {remainder, dividend}, restoring step shifts quotient bits into the low half.
  // With a zero divisor every trial subtract succeeds, yielding all-ones quotient and rs as remainder.
  always_comb begin
    add_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    diff    = {1'b0, acc[63:31]} - {2'b00, opnd};
    if (is_div) begin
      acc_next = diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_next = {add_sum, acc[31:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cand_valid) state_next = S_BUSY;
      S_BUSY:  if (cnt == 5'd31) state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      tag_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (cand_valid) begin
          cnt   <= '0;
          op_q  <= slots[cand_idx].op;
          rd_q  <= slots[cand_idx].rd;
          tag_q <= slots[cand_idx].tag;
          idx_q <= cand_idx;
          if (slots[cand_idx].op[1]) begin
            opnd <= reg_out13;
            acc  <= {32'd0, reg_out12};
          end else begin
            opnd <= reg_out12;
            acc  <= {32'd0, reg_out13};
          end
        end
        S_BUSY: begin
          cnt <= cnt + 5'd1;
          acc <= acc_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stamp_arr        = '0;
    stamp_in         = '0;
    take_arr         = '0;
    take_in          = '0;
    reg_search_out12 = '0;
    reg_search_out13 = '0;
    reg_search_in12  = '0;
    reg_in12         = '0;
    reg_in12_start   = 1'b0;
    case (state)
      S_IDLE: if (cand_valid && !reset) begin
        reg_search_out12 = slots[cand_idx].rs;
        reg_search_out13 = slots[cand_idx].rt;
      end
      S_BUSY: if (cnt == 5'd0) begin
        stamp_in[idx_q]  = 1'b1;
        stamp_arr[idx_q] = ST_ISSUED;
        take_in[idx_q]   = 1'b1;
        take_arr[idx_q]  = rd_q;
      end
      S_WB: if (wb_match) begin
        reg_in12_start   = 1'b1;
        reg_search_in12  = rd_q;
        reg_in12         = op_q[0] ? acc[63:32] : acc[31:0];
        stamp_in[idx_q]  = 1'b1;
        stamp_arr[idx_q] = ST_DONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table of single operations plus priority, flush and reset sequences.
// A small pool model marks slots ISSUED/cleared from the stamp strobes, as the conveyor would.
module tb_mdu;

  localparam logic [5:0] OP_MUL    = 6'h20;
  localparam logic [5:0] OP_MULHU  = 6'h21;
  localparam logic [5:0] OP_DIVU   = 6'h22;
  localparam logic [5:0] OP_REMU   = 6'h23;
  localparam logic [2:0] ST_READY  = 3'd1;
  localparam logic [2:0] ST_ISSUED = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0][2:0]  states;
  logic [7:0][87:0] slots_tb;
  logic [23:0]      stamp_flat;
  logic [7:0]       stamp_in;
  logic [39:0]      take_flat;
  logic [7:0]       take_in;
  logic [4:0]       reg_search_out12, reg_search_out13, reg_search_in12;
  logic [31:0]      reg_out12, reg_out13, reg_in12;
  logic             reg_in12_start;
  logic [31:0]      rf [32];

  assign reg_out12 = rf[reg_search_out12];
  assign reg_out13 = rf[reg_search_out13];

  mdu dut (
    .clk              (clk),
    .reset            (reset),
    .reg_start_flat   (states),
    .reg_out_flat     (slots_tb),
    .stamp_flat       (stamp_flat),
    .stamp_in         (stamp_in),
    .take_flat        (take_flat),
    .take_in          (take_in),
    .reg_search_out12 (reg_search_out12),
    .reg_out12        (reg_out12),
    .reg_search_out13 (reg_search_out13),
    .reg_out13        (reg_out13),
    .reg_search_in12  (reg_search_in12),
    .reg_in12         (reg_in12),
    .reg_in12_start   (reg_in12_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] s_stamp_flat;
  logic [7:0]  s_stamp_in;
  logic [39:0] s_take_flat;
  logic [7:0]  s_take_in;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic        s_we;

  typedef struct {
    int          slot;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [4:0]  rd;
    logic [2:0]  tag;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [87:0] mk_cmd(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [2:0] tag);
    return {op, rs, rt, rd, 32'hDEADBEEF, 32'h00001000, tag};
  endfunction

  // Advance to the next falling edge, snapshot outputs, then let the pool react to stamps.
  task automatic tick();
    @(negedge clk);
    s_stamp_flat = stamp_flat;
    s_stamp_in   = stamp_in;
    s_take_flat  = take_flat;
    s_take_in    = take_in;
    s_waddr      = reg_search_in12;
    s_wdata      = reg_in12;
    s_we         = reg_in12_start;
    for (int k = 0; k < 8; k++) begin
      if (s_stamp_in[k]) begin
        if (s_stamp_flat[3*k +: 3] == ST_ISSUED) states[k] = ST_ISSUED;
        else if (s_stamp_flat[3*k +: 3] == ST_DONE) states[k] = 3'd0;
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    int c;
    rf[20] = v.a;
    rf[21] = v.b;
    slots_tb[v.slot] = mk_cmd(v.op, 5'd20, 5'd21, v.rd, v.tag);
    states[v.slot]   = ST_READY;
    #1;
    check("rs_addr", reg_search_out12, 5'd20);
    check("rt_addr", reg_search_out13, 5'd21);
    tick();
    check("issue_stamp_in", s_stamp_in, 8'(1) << v.slot);
    check("issue_stamp_flat", s_stamp_flat, 24'(ST_ISSUED) << (3 * v.slot));
    check("issue_take_in", s_take_in, 8'(1) << v.slot);
    check("issue_take_flat", s_take_flat, 40'(v.rd) << (5 * v.slot));
    c = 1;
    while (c <= 40) begin
      tick();
      c++;
      if (s_we) break;
    end
    check("write_cycle", c, 33);
    check("write_addr", s_waddr, v.rd);
    check("write_data", s_wdata, v.exp);
    check("done_stamp_flat", s_stamp_flat, 24'(ST_DONE) << (3 * v.slot));
    slots_tb[v.slot] = '0;
    states[v.slot]   = 3'd0;
    tick();
  endtask

  initial begin
    int n, c1, c2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;

    vecs[0] = '{2, OP_MUL,   32'd7,        32'd6,        32'd42,       5'd9,  3'd5};
    vecs[1] = '{0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd12, 3'd1};
    vecs[2] = '{7, OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'd13, 3'd2};
    vecs[3] = '{4, OP_DIVU,  32'd100,      32'd7,        32'd14,       5'd14, 3'd3};
    vecs[4] = '{4, OP_REMU,  32'd100,      32'd7,        32'd2,        5'd15, 3'd4};
    vecs[5] = '{1, OP_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 5'd16, 3'd6};
    vecs[6] = '{6, OP_REMU,  32'd100,      32'd0,        32'd100,      5'd17, 3'd7};
    vecs[7] = '{3, OP_MULHU, 32'h80000000, 32'd4,        32'd2,        5'd0,  3'd0};
    vecs[8] = '{5, OP_MUL,   32'h12345678, 32'h10,       32'h23456780, 5'd31, 3'd3};
    vecs[9] = '{0, OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 5'd18, 3'd2};

    reset    = 1'b1;
    states   = '0;
    slots_tb = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;

    // Reset state: a ready candidate must not leak onto the read addresses.
    slots_tb[0] = mk_cmd(OP_MUL, 5'd3, 5'd4, 5'd5, 3'd1);
    states[0]   = ST_READY;
    tick();
    tick();
    check("reset_outputs", {stamp_flat, stamp_in, take_flat, take_in, reg_in12_start, reg_in12,
                            reg_search_in12, reg_search_out12, reg_search_out13}, '0);
    states[0]   = 3'd0;
    slots_tb[0] = '0;
    reset = 1'b0;
    tick();
    check("idle_no_cand_addr", {reg_search_out12, reg_search_out13}, '0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Slots 1 and 5 ready together: slot1 first, slot5 one full op (34 cycles) later.
    rf[3] = 32'd3;  rf[4] = 32'd5;  rf[5] = 32'd4;  rf[6] = 32'd9;
    slots_tb[1] = mk_cmd(OP_MUL, 5'd3, 5'd4, 5'd10, 3'd1);
    slots_tb[5] = mk_cmd(OP_MUL, 5'd5, 5'd6, 5'd11, 3'd2);
    states[1] = ST_READY;
    states[5] = ST_READY;
    #1;
    check("prio_rs_addr", reg_search_out12, 5'd3);
    tick();
    check("prio_issue_slot1", s_stamp_in, 8'h02);
    n = 0; c1 = 0; c2 = 0; a1 = '0; a2 = '0; d1 = '0; d2 = '0;
    for (int c = 2; c <= 80; c++) begin
      tick();
      if (s_we) begin
        if (n == 0) begin c1 = c; a1 = s_waddr; d1 = s_wdata; end
        else        begin c2 = c; a2 = s_waddr; d2 = s_wdata; end
        n++;
      end
    end
    check("prio_write_count", n, 2);
    check("prio_first_cycle", c1, 33);
    check("prio_first", {a1, d1}, {5'd10, 32'd15});
    check("prio_second_cycle", c2, 67);
    check("prio_second", {a2, d2}, {5'd11, 32'd36});
    slots_tb[1] = '0; slots_tb[5] = '0; states[1] = 3'd0; states[5] = 3'd0;

    // Tag rewritten while BUSY: both write and DONE stamp are dropped.
    rf[20] = 32'd9; rf[21] = 32'd9;
    slots_tb[3] = mk_cmd(OP_MUL, 5'd20, 5'd21, 5'd7, 3'd2);
    states[3]   = ST_READY;
    tick();
    check("flush_issue", s_stamp_in, 8'h08);
    repeat (10) tick();
    slots_tb[3][2:0] = 3'd6;
    n = 0; c1 = 0;
    for (int c = 12; c <= 45; c++) begin
      tick();
      if (s_we) n++;
      if (s_stamp_in != 8'h00) c1++;
    end
    check("flush_no_write", n, 0);
    check("flush_no_stamp", c1, 0);
    slots_tb[3] = '0; states[3] = 3'd0;
    run_op(vecs[0]);

    // Reset at cnt==10 abandons the op; a fresh op then completes normally.
    slots_tb[6] = mk_cmd(OP_MUL, 5'd20, 5'd21, 5'd8, 3'd1);
    states[6]   = ST_READY;
    tick();
    check("rst_issue", s_stamp_in, 8'h40);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {stamp_flat, stamp_in, take_flat, take_in, reg_in12_start, reg_in12,
                              reg_search_in12, reg_search_out12, reg_search_out13}, '0);
    tick();
    tick();
    reset = 1'b0;
    slots_tb[6] = '0; states[6] = 3'd0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (s_we || s_stamp_in != 8'h00) n++;
    end
    check("rst_no_write", n, 0);
    run_op(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
